// File: rtl/pwm_frame_feeder_if.sv
// Bundle between the duty-word source and pwm_frame_feeder, carrying the source handshake and the PWM frame stream.
// A word moves on a rising edge where in_valid && in_ready; the source keeps in_data stable while it waits.
interface pwm_frame_feeder_if #(
   parameter int DWIDTH = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DWIDTH-1:0] in_data;
   logic              flush;
   logic              start;
   logic [DWIDTH-1:0] data;
   logic              busy;
   logic              replay;
   logic [15:0]       frames_sent;

   modport master (
      output in_valid, in_data, flush,
      input  in_ready, start, data, busy, replay, frames_sent
   );

   modport slave (
      input  in_valid, in_data, flush,
      output in_ready, start, data, busy, replay, frames_sent
   );
endinterface

// File: rtl/pwm_frame_feeder.sv
// Ping-pong frame buffer that emits each frame as a start pulse plus STAGE words for the PWM.
// Define PWM_FEEDER_REPEAT_EN to replay the last streamed frame whenever no new frame is ready.
module pwm_frame_feeder #(
   parameter int STAGE      = 8,
   parameter int DWIDTH     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clkfordata,
   input  logic              rst_n,
   pwm_frame_feeder_if.slave bus,
   output logic [1:0]        dbg_state_o
);
   localparam int IW = $clog2(STAGE);
   localparam logic [IW-1:0] LAST = IW'(STAGE - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [DWIDTH-1:0] mem_q [2][STAGE];
   logic [1:0]        full_q, full_d;
   logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [IW-1:0]     wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic [3:0]        gap_cnt_q, gap_cnt_d;
   logic              start_q, start_d;
   logic [DWIDTH-1:0] data_q, data_d;
   logic [15:0]       frames_q, frames_d;
   logic              in_ready, accept, replaying;

`ifdef PWM_FEEDER_REPEAT_EN
   logic [DWIDTH-1:0] shadow_q [STAGE];
   logic [DWIDTH-1:0] shadow_d [STAGE];
   logic              shadow_vld_q, shadow_vld_d, replay_q, replay_d;
   assign replaying = replay_q;
`else
   assign replaying = 1'b0;
`endif

   assign in_ready = !full_q[wr_bank_q] && !bus.flush;
   assign accept   = bus.in_valid && in_ready;

   // Storage needs no reset: the full flags decide whether a bank's contents are meaningful.
   always_ff @(posedge clkfordata) begin
      if (accept) mem_q[wr_bank_q][wr_idx_q] <= bus.in_data;
   end

   always_comb begin
      state_d   = state_q;
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      rd_bank_d = rd_bank_q;
      rd_idx_d  = rd_idx_q;
      gap_cnt_d = gap_cnt_q;
      start_d   = 1'b0;
      data_d    = '0;
      frames_d  = frames_q;
`ifdef PWM_FEEDER_REPEAT_EN
      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      replay_d     = replay_q;
`endif

      if (bus.flush) begin
         wr_idx_d = '0;
      end else if (accept) begin
         if (wr_idx_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_idx_d          = '0;
         end else begin
            wr_idx_d = wr_idx_q + IW'(1);
         end
      end

      case (state_q)
         IDLE: begin
`ifdef PWM_FEEDER_REPEAT_EN
            replay_d = 1'b0;
`endif
            if (full_q[rd_bank_q]) begin
               start_d  = 1'b1;
               data_d   = mem_q[rd_bank_q][0];
               rd_idx_d = IW'(1);
               state_d  = SEND;
`ifdef PWM_FEEDER_REPEAT_EN
               shadow_d[0] = mem_q[rd_bank_q][0];
`endif
            end
`ifdef PWM_FEEDER_REPEAT_EN
            else if (shadow_vld_q) begin
               start_d  = 1'b1;
               data_d   = shadow_q[0];
               rd_idx_d = IW'(1);
               replay_d = 1'b1;
               state_d  = SEND;
            end
`endif
         end
         SEND: begin
`ifdef PWM_FEEDER_REPEAT_EN
            data_d = replaying ? shadow_q[rd_idx_q] : mem_q[rd_bank_q][rd_idx_q];
            if (!replaying) shadow_d[rd_idx_q] = mem_q[rd_bank_q][rd_idx_q];
`else
            data_d = mem_q[rd_bank_q][rd_idx_q];
`endif
            if (rd_idx_q == LAST) begin
               rd_idx_d  = '0;
               gap_cnt_d = '0;
               state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
               if (!replaying) begin
                  full_d[rd_bank_q] = 1'b0;
                  rd_bank_d         = !rd_bank_q;
                  frames_d          = frames_q + 16'd1;
`ifdef PWM_FEEDER_REPEAT_EN
                  shadow_vld_d = 1'b1;
`endif
               end
            end else begin
               rd_idx_d = rd_idx_q + IW'(1);
            end
         end
         GAP: begin
`ifdef PWM_FEEDER_REPEAT_EN
            replay_d = 1'b0;
`endif
            // Counting up to GAP_CYCLES inclusive leaves an idle bus cycle before IDLE can restart.
            if (gap_cnt_q == 4'(GAP_CYCLES)) state_d = IDLE;
            else gap_cnt_d = gap_cnt_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clkfordata or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         rd_bank_q <= 1'b0;
         rd_idx_q  <= '0;
         gap_cnt_q <= '0;
         start_q   <= 1'b0;
         data_q    <= '0;
         frames_q  <= '0;
`ifdef PWM_FEEDER_REPEAT_EN
         shadow_q     <= '{default: '0};
         shadow_vld_q <= 1'b0;
         replay_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         wr_idx_q  <= wr_idx_d;
         rd_bank_q <= rd_bank_d;
         rd_idx_q  <= rd_idx_d;
         gap_cnt_q <= gap_cnt_d;
         start_q   <= start_d;
         data_q    <= data_d;
         frames_q  <= frames_d;
`ifdef PWM_FEEDER_REPEAT_EN
         shadow_q     <= shadow_d;
         shadow_vld_q <= shadow_vld_d;
         replay_q     <= replay_d;
`endif
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.start       = start_q;
   assign bus.data        = data_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.frames_sent = frames_q;
`ifdef PWM_FEEDER_REPEAT_EN
   assign bus.replay      = replay_q;
`else
   assign bus.replay      = 1'b0;
`endif
   assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_pwm_frame_feeder.sv
// Bench for pwm_frame_feeder: random and directed duty words against a frame-level model of accepted words.
module tb_pwm_frame_feeder;
   localparam int STAGE = 8;
   localparam int DW    = 8;
   localparam int GAP   = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   pwm_frame_feeder_if #(.DWIDTH(DW)) bus ();

   pwm_frame_feeder #(.STAGE(STAGE), .DWIDTH(DW), .GAP_CYCLES(GAP)) dut (
      .clkfordata (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Frame-level model: accepted words, grouped into frames in arrival order.
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] part_q[$];
   logic [DW-1:0] last_frame [STAGE];
   logic [DW-1:0] got [STAGE];
   logic [15:0]   exp_sent = 16'd0;
   bit            last_valid = 1'b0;
   bit            in_frame = 1'b0;
   bit            cur_replay = 1'b0;
   bit            done = 1'b0;
   int            formed = 0, released = 0;
   int            cyc = 0, last_start = -1, widx = 0, replay_frames = 0;
   int            new_starts[$];

   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            in_frame = 1'b0;
         end else begin
`ifndef PWM_FEEDER_REPEAT_EN
            check("replay_off", 32'(bus.replay), 32'd0);
`endif
            if (bus.start) begin
               if (in_frame) check("start_overlap", 32'(widx), 32'(STAGE));
               if (last_start >= 0)
                  check("start_spacing", 32'((cyc - last_start) >= STAGE + GAP + 1), 32'd1);
               last_start = cyc;
               in_frame   = 1'b1;
               widx       = 1;
               got[0]     = bus.data;
               cur_replay = bus.replay;
               if (!cur_replay) begin
                  new_starts.push_back(cyc);
                  check("frame_pending", 32'(exp_q.size() >= STAGE), 32'd1);
               end else begin
                  check("replay_src", 32'(last_valid), 32'd1);
               end
            end else if (in_frame) begin
               check("replay_hold", 32'(bus.replay), 32'(cur_replay));
               check("busy_send", 32'(bus.busy), 32'd1);
               got[widx] = bus.data;
               widx++;
               if (widx == STAGE) begin
                  in_frame = 1'b0;
                  if (cur_replay) begin
                     replay_frames++;
                     for (int i = 0; i < STAGE; i++) check("replay_word", 32'(got[i]), 32'(last_frame[i]));
                  end else if (exp_q.size() >= STAGE) begin
                     for (int i = 0; i < STAGE; i++) begin
                        e = exp_q.pop_front();
                        check("word", 32'(got[i]), 32'(e));
                        last_frame[i] = e;
                     end
                     last_valid = 1'b1;
                     exp_sent   = exp_sent + 16'd1;
                     released++;
                  end
               end
            end else begin
               check("idle_data", 32'(bus.data), 32'd0);
            end
            check("frames_sent", 32'(bus.frames_sent), 32'(exp_sent));
         end
      end
   end

   // All driver tasks start and end on a falling edge.
   task automatic push_word(input logic [DW-1:0] w);
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      #1;
      while (!bus.in_ready && waited < 300) begin
         check("in_ready_stall", 32'(bus.in_ready), 32'((formed - released) < 2));
         @(negedge clk);
         #1;
         waited++;
      end
      check("in_ready", 32'(bus.in_ready), 32'((formed - released) < 2));
      if (bus.in_ready) begin
         part_q.push_back(w);
         if (part_q.size() == STAGE) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
            formed++;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic do_flush();
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      #1;
      check("ready_in_flush", 32'(bus.in_ready), 32'd0);
      part_q.delete();
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || in_frame) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", 32'(n < 500), 32'd1);
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic reset_model();
      exp_q.delete();
      part_q.delete();
      new_starts.delete();
      formed     = 0;
      released   = 0;
      exp_sent   = 16'd0;
      last_valid = 1'b0;
      in_frame   = 1'b0;
      last_start = -1;
   endtask

   initial begin
      int n;
      int k;
      int s;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.flush    = 1'b0;
      #1;
      check("rst_start", 32'(bus.start), 32'd0);
      check("rst_data", 32'(bus.data), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_replay", 32'(bus.replay), 32'd0);
      check("rst_frames", 32'(bus.frames_sent), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.in_ready), 32'd1);

      // Words 00..07 back-to-back: start lands one edge after the 8th accept.
      for (int i = 0; i < STAGE; i++) push_word(DW'(i));
      check("start_not_early", 32'(bus.start), 32'd0);
      @(negedge clk);
      check("start_latency", 32'(bus.start), 32'd1);
      repeat (STAGE) @(negedge clk);
      check("gap0_data", 32'(bus.data), 32'd0);
      check("gap0_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("gap1_data", 32'(bus.data), 32'd0);
      check("gap1_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      wait_drain();
      check("one_frame", 32'(bus.frames_sent), 32'd1);

      // 24 words 10..27: both banks fill, three frames at minimum spacing.
      new_starts.delete();
      for (int i = 0; i < 3 * STAGE; i++) push_word(8'h10 + DW'(i));
      check("ready_both_full", 32'(bus.in_ready), 32'd0);
      wait_drain();
      check("three_starts", 32'(new_starts.size()), 32'd3);
      if (new_starts.size() == 3) begin
         check("spacing_01", 32'(new_starts[1] - new_starts[0]), 32'(STAGE + GAP + 1));
         check("spacing_12", 32'(new_starts[2] - new_starts[1]), 32'(STAGE + GAP + 1));
      end

      // 5 words, flush, then 40..47.
      for (int i = 0; i < 5; i++) push_word(DW'($urandom_range(0, 255)));
      do_flush();
      for (int i = 0; i < STAGE; i++) push_word(8'h40 + DW'(i));
      wait_drain();
      check("after_flush", 32'(bus.frames_sent), 32'(exp_sent));

      // Random words with random idle gaps and a random partial flush.
      for (int f = 0; f < 6; f++) begin
         if (f == 2) begin
            k = $urandom_range(1, STAGE - 1);
            for (int i = 0; i < k; i++) push_word(DW'($urandom_range(0, 255)));
            do_flush();
         end
         for (int i = 0; i < STAGE; i++) begin
            push_word(DW'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      wait_drain();

      // Asynchronous reset during word 4 of a frame.
      for (int i = 0; i < STAGE; i++) push_word(8'h60 + DW'(i));
      n = 0;
      while (!bus.start && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", 32'(bus.start), 32'd1);
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      reset_model();
      #1;
      check("arst_start", 32'(bus.start), 32'd0);
      check("arst_data", 32'(bus.data), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_frames", 32'(bus.frames_sent), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("arst_ready", 32'(bus.in_ready), 32'd1);
      repeat (30) @(negedge clk);
      check("no_residual", 32'(new_starts.size()), 32'd0);

      // frames_sent wrap.
      exp_sent = 16'hFFFE;
      force dut.frames_q = 16'hFFFE;
      repeat (2) @(negedge clk);
      release dut.frames_q;
      check("wrap_preset", 32'(bus.frames_sent), 32'hFFFE);
      for (int i = 0; i < STAGE; i++) push_word(DW'($urandom_range(0, 255)));
      wait_drain();
      check("wrap_ffff", 32'(bus.frames_sent), 32'hFFFF);
      for (int i = 0; i < STAGE; i++) push_word(DW'($urandom_range(0, 255)));
      wait_drain();
      check("wrap_zero", 32'(bus.frames_sent), 32'h0000);

`ifdef PWM_FEEDER_REPEAT_EN
      // Frame A0..A7 then silence: it replays; B0..B7 then takes over.
      for (int i = 0; i < STAGE; i++) push_word(8'hA0 + DW'(i));
      wait_drain();
      s = replay_frames;
      repeat (40) @(negedge clk);
      check("replays_seen", 32'((replay_frames - s) >= 2), 32'd1);
      check("replay_no_count", 32'(bus.frames_sent), 32'd1);
      for (int i = 0; i < STAGE; i++) push_word(8'hB0 + DW'(i));
      wait_drain();
      check("b_counted", 32'(bus.frames_sent), 32'd2);
      check("b_shadow0", 32'(last_frame[0]), 32'hB0);
`else
      s = replay_frames;
      repeat (40) @(negedge clk);
      check("no_replays", 32'(replay_frames - s), 32'd0);
`endif

      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      check("watchdog_done", 32'(done), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
